// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, assembles a 24-bit instruction from three byte reads
// over a req/ack memory port, and offers {pc, instr} to the datapath under valid/ready.
module instr_fetch_unit #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [23:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [7:0]       imem_rdata,
  output logic [23:0]      pc,
  output logic [23:0]      instr,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic [23:0]      next_pc,
  output logic [CNT_W-1:0] retired,
  output logic             fsm_state
);

  // Handshakes:
  //   imem: a byte transfers on a cycle where imem_req & imem_ack; imem_req stays
  //         high (address stable) until then. imem_ack while imem_req=0 is ignored.
  //   datapath: instr/pc transfer on a cycle where instr_valid & instr_ready;
  //         instr/pc are stable while instr_valid=1 and instr_ready=0.

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] byte_idx;

  assign fsm_state = state;
  assign imem_addr = pc + {22'd0, byte_idx};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      byte_idx    <= 2'd0;
      pc          <= RESET_PC;
      instr       <= 24'd0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      retired     <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!imem_req) begin
            // Only reachable right after reset release: start the first request.
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            case (byte_idx)
              2'd0:    instr[23:16] <= imem_rdata;
              2'd1:    instr[15:8]  <= imem_rdata;
              default: instr[7:0]   <= imem_rdata;
            endcase
            if (byte_idx == 2'd2) begin
              state       <= HOLD;
              byte_idx    <= 2'd0;
              imem_req    <= 1'b0;
              instr_valid <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            // Consume: next_pc is taken as-is, including unaligned branch targets.
            pc          <= next_pc;
            instr_valid <= 1'b0;
            byte_idx    <= 2'd0;
            imem_req    <= 1'b1;
            state       <= FETCH;
            if (retired != {CNT_W{1'b1}}) retired <= retired + CNT_W'(1);
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
